// File: rtl/tiny_soc_pkg.sv
// Shared address map, status layout and access decode for the core data-side bridge.
package tiny_soc_pkg;

  localparam logic [3:0] RGN_RAM    = 4'h0;
  localparam logic [3:0] RGN_PERIPH = 4'h1;

  localparam logic [7:0] PB_TXDATA = 8'h00;
  localparam logic [7:0] PB_STATUS = 8'h04;
  localparam logic [7:0] PB_CTRL   = 8'h08;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_ERR     = 3;
  localparam int ST_CNT_LSB = 8;

  typedef enum logic [2:0] {ACC_RAM, ACC_TX, ACC_STAT, ACC_CTRL, ACC_UNMAP} acc_e;

  // Word address (byte address bits [31:2]); the periph region code is passed in
  // so the window base stays a parameter of the bridge.
  function automatic acc_e decode(input logic [29:0] wa, input logic [3:0] prgn);
    acc_e a;
    a = ACC_UNMAP;
    if (wa[29:26] == RGN_RAM) a = ACC_RAM;
    else if (wa[29:26] == prgn && wa[25:6] == '0) begin
      case ({wa[5:0], 2'b00})
        PB_TXDATA: a = ACC_TX;
        PB_STATUS: a = ACC_STAT;
        PB_CTRL:   a = ACC_CTRL;
        default:   a = ACC_UNMAP;
      endcase
    end
    return a;
  endfunction

endpackage

// File: rtl/dmem_bus_bridge_sync_fifo.sv
// Single-clock posted-write FIFO; a push while full is accepted only if a pop frees a slot the same cycle.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q, wr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem_q[rd_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage is reset so the bus data reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/dmem_bus_bridge.sv
// M-stage data slave: local data RAM plus a peripheral window with posted writes.
// Build option DMEM_BRIDGE_ERR_EN adds a sticky unmapped-access error flag.
module dmem_bus_bridge
  import tiny_soc_pkg::*;
#(
  parameter int          RAM_WORDS   = 256,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [31:0] PERIPH_BASE = 32'h1000_0000,
  localparam int         AW = $clog2(RAM_WORDS),
  localparam int         CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic        MemWriteM,
  output logic [31:0] ReadDataM,
  output logic        pb_valid,
  output logic [31:0] pb_wdata,
  input  logic        pb_ready,
  output logic        irq_ovf
);

  acc_e          acc;
  logic [AW-1:0] ram_idx;
  logic [31:0]   ram_q [RAM_WORDS];
  logic          push, pop, full, empty, ovf_evt, clr;
  logic [CW-1:0] count;
  logic          ovf_q, ovf_d, err_q;
  logic [31:0]   status;

  assign acc     = decode(ALUResultM[31:2], PERIPH_BASE[31:28]);
  assign ram_idx = ALUResultM[AW+1:2];

  always_ff @(posedge clk)
    if (MemWriteM && acc == ACC_RAM) ram_q[ram_idx] <= WriteDataM;

  assign push     = MemWriteM && acc == ACC_TX;
  assign pop      = pb_valid && pb_ready;
  assign pb_valid = !empty;
  assign ovf_evt  = push && full && !pop;
  assign clr      = MemWriteM && acc == ACC_CTRL && WriteDataM[0];

  sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .pop   (pop),
    .din   (WriteDataM),
    .dout  (pb_wdata),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Set beats clear when both land in the same cycle.
  assign ovf_d = ovf_evt ? 1'b1 : (clr ? 1'b0 : ovf_q);

  always_ff @(posedge clk or negedge reset)
    if (!reset) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;

`ifdef DMEM_BRIDGE_ERR_EN
  logic err_d;
  // No access strobe from the core, so every cycle's address is decoded.
  assign err_d = (acc == ACC_UNMAP) ? 1'b1 : (clr ? 1'b0 : err_q);

  always_ff @(posedge clk or negedge reset)
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
`else
  assign err_q = 1'b0;
`endif

  always_comb begin
    status                    = '0;
    status[ST_CNT_LSB +: 8]   = 8'(count);
    status[ST_ERR]            = err_q;
    status[ST_OVF]            = ovf_q;
    status[ST_FULL]           = full;
    status[ST_EMPTY]          = empty;
  end

  always_comb begin
    ReadDataM = '0;
    case (acc)
      ACC_RAM:  ReadDataM = ram_q[ram_idx];
      ACC_STAT: ReadDataM = status;
      default:  ReadDataM = '0;
    endcase
  end

  assign irq_ovf = ovf_q | err_q;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Scoreboarded bench for dmem_bus_bridge: RAM, posted writes, overflow, reset, error flag.
module tb_dmem_bus_bridge;

  localparam int          D    = 4;
  localparam logic [31:0] TX   = 32'h1000_0000;
  localparam logic [31:0] STAT = 32'h1000_0004;
  localparam logic [31:0] CTRL = 32'h1000_0008;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] ALUResultM = '0;
  logic [31:0] WriteDataM = '0;
  logic        MemWriteM = 1'b0;
  logic [31:0] ReadDataM;
  logic        pb_valid;
  logic [31:0] pb_wdata;
  logic        pb_ready = 1'b0;
  logic        irq_ovf;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] sb_q [$];
  logic        exp_ovf = 1'b0;

  dmem_bus_bridge #(.RAM_WORDS(256), .FIFO_DEPTH(D), .PERIPH_BASE(32'h1000_0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .MemWriteM  (MemWriteM),
    .ReadDataM  (ReadDataM),
    .pb_valid   (pb_valid),
    .pb_wdata   (pb_wdata),
    .pb_ready   (pb_ready),
    .irq_ovf    (irq_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] st(input int cnt, input logic ovf, input logic err);
    logic [7:0] c8;
    c8 = 8'(cnt);
    return {16'b0, c8, 4'b0, err, ovf, (cnt == D), (cnt == 0)};
  endfunction

  // Handshake completes on the next rising edge; inputs are stable here.
  always @(negedge clk) begin
    if (reset && pb_valid && pb_ready) begin
      if (sb_q.size() == 0) chk("pop_unexpected", pb_wdata, 32'hxxxx_xxxx);
      else chk("pop_data", pb_wdata, sb_q.pop_front());
    end
  end

  // One bus cycle; called at posedge+1, returns at the next posedge+1.
  task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic we, input logic rdy);
    ALUResultM = a; WriteDataM = d; MemWriteM = we; pb_ready = rdy;
    if (we && a == CTRL && d[0]) exp_ovf = 1'b0;
    if (we && a == TX) begin
      if (sb_q.size() < D || (rdy && sb_q.size() > 0)) sb_q.push_back(d);
      else exp_ovf = 1'b1;
    end
    @(posedge clk); #1;
    MemWriteM = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    ALUResultM = a;
    #1;
    chk(tag, ReadDataM, exp);
  endtask

  task automatic drain(input string tag);
    pb_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (sb_q.size() == 0) break;
      @(posedge clk); #1;
    end
    chk({tag, "_left"}, 32'(sb_q.size()), 32'd0);
    pb_ready = 1'b0;
    chk({tag, "_valid"}, {31'b0, pb_valid}, 32'd0);
    rd({tag, "_status"}, STAT, st(0, exp_ovf, 1'b0));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, pb_valid}, 32'd0);
    chk("rst_wdata", pb_wdata, 32'd0);
    chk("rst_irq", {31'b0, irq_ovf}, 32'd0);
    reset = 1'b1;
    rd("rst_status", STAT, 32'h0000_0001);

    // RAM
    cyc(32'h10, 32'hDEAD_BEEF, 1'b1, 1'b0);
    rd("ram_rd", 32'h10, 32'hDEAD_BEEF);
    rd("ram_alias", 32'h410, 32'hDEAD_BEEF);
    cyc(32'h14, 32'h1234_5678, 1'b1, 1'b0);
    rd("ram_rd14", 32'h17, 32'h1234_5678);
    ALUResultM = 32'h14; WriteDataM = 32'hCAFE_F00D; MemWriteM = 1'b1;
    #1 chk("ram_rdw_old", ReadDataM, 32'h1234_5678);
    @(posedge clk); #1;
    MemWriteM = 1'b0;
    chk("ram_rdw_new", ReadDataM, 32'hCAFE_F00D);

    // Post and drain
    cyc(TX, 32'h11, 1'b1, 1'b0);
    cyc(TX, 32'h22, 1'b1, 1'b0);
    chk("post_valid", {31'b0, pb_valid}, 32'd1);
    chk("post_head", pb_wdata, 32'h11);
    rd("post_status", STAT, 32'h0000_0200);
    rd("post_rd_tx", TX, 32'd0);
    drain("post");

    // Overflow
    for (int i = 0; i < 5; i++) cyc(TX, 32'hA0 + 32'(i), 1'b1, 1'b0);
    rd("ovf_status", STAT, 32'h0000_0406);
    chk("ovf_irq", {31'b0, irq_ovf}, 32'd1);
    chk("ovf_head_stable", pb_wdata, 32'hA0);
    cyc(CTRL, 32'h1, 1'b1, 1'b0);
    rd("ovf_clr_status", STAT, 32'h0000_0402);
    chk("ovf_clr_irq", {31'b0, irq_ovf}, 32'd0);
    drain("ovf");

    // Full with simultaneous pop and push
    for (int i = 0; i < 4; i++) cyc(TX, 32'hB0 + 32'(i), 1'b1, 1'b0);
    cyc(TX, 32'h55, 1'b1, 1'b1);
    pb_ready = 1'b0;
    rd("fpp_status", STAT, 32'h0000_0402);
    chk("fpp_irq", {31'b0, irq_ovf}, 32'd0);
    chk("fpp_head", pb_wdata, 32'hB1);
    drain("fpp");

    // Random traffic through the wrapping pointers
    for (int i = 0; i < 40; i++)
      cyc(TX, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    pb_ready = 1'b0;
    rd("rnd_status", STAT, st(sb_q.size(), exp_ovf, 1'b0));
    chk("rnd_irq", {31'b0, irq_ovf}, {31'b0, exp_ovf});
    cyc(CTRL, 32'h1, 1'b1, 1'b0);
    drain("rnd");

    // Reset mid-transfer
    for (int i = 0; i < 3; i++) cyc(TX, 32'hC0 + 32'(i), 1'b1, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("mrst_valid", {31'b0, pb_valid}, 32'd0);
    chk("mrst_wdata", pb_wdata, 32'd0);
    reset = 1'b1;
    sb_q.delete();
    exp_ovf = 1'b0;
    @(posedge clk); #1;
    rd("mrst_status", STAT, 32'h0000_0001);

    // Unmapped access
    ALUResultM = 32'h1000_000C;
    #1 chk("unmap_rd", ReadDataM, 32'd0);
    cyc(32'h1000_000C, 32'd0, 1'b0, 1'b0);
`ifdef DMEM_BRIDGE_ERR_EN
    rd("err_status", STAT, 32'h0000_0009);
    chk("err_irq", {31'b0, irq_ovf}, 32'd1);
`else
    rd("err_status", STAT, 32'h0000_0001);
    chk("err_irq", {31'b0, irq_ovf}, 32'd0);
`endif
    cyc(CTRL, 32'h1, 1'b1, 1'b0);
    rd("err_clr_status", STAT, 32'h0000_0001);
    chk("err_clr_irq", {31'b0, irq_ovf}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
